// File: rtl/uart_rx_if.sv
// Ready/valid byte stream carrying received UART data from uart_rx to its consumer.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, ready/valid output.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx_pin,
    uart_rx_if.master rx,
    output logic      frame_err,
    output logic      overrun,
    output logic      busy
);
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = (HALF > 0) ? CW'(HALF - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          rx_s_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          busy_q;
    logic          frame_err_q;
    logic          overrun_q;
    logic          push;
    logic          pop;

    // A good stop sample pushes the assembled byte on the same edge.
    assign push = (state_q == S_STOP) && (cnt_q == '0) && rx_s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx_pin;
            rx_s_q      <= sync1_q;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        busy_q <= 1'b1;
                        idx_q  <= '0;
                        if (HALF == 0) begin
                            state_q <= S_DATA;
                            cnt_q   <= CNT_BIT;
                        end else begin
                            state_q <= S_START;
                            cnt_q   <= CNT_HALF;
                        end
                    end
                end
                S_START: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (!rx_s_q) begin
                        state_q <= S_DATA;
                        cnt_q   <= CNT_BIT;
                        idx_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= CNT_BIT;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        // Line held low through stop: wait for idle so a break is not a new start.
                        frame_err_q <= 1'b1;
                        state_q     <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] wp_q;
    logic [1:0] rp_q;
    logic [2:0] count_q;
    logic       push_ok;

    assign pop     = (count_q != 3'd0) && rx.rx_ready;
    assign push_ok = push && ((count_q != 3'd4) || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && !push_ok;
            if (push_ok) begin
                mem_q[wp_q] <= shift_q;
                wp_q        <= wp_q + 2'd1;
            end
            if (pop) begin
                rp_q <= rp_q + 2'd1;
            end
            count_q <= count_q + {2'b00, push_ok} - {2'b00, pop};
        end
    end

    assign rx.rx_data  = mem_q[rp_q];
    assign rx.rx_valid = (count_q != 3'd0);
`else
    logic [7:0] data_q;
    logic       valid_q;

    assign pop = valid_q && rx.rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (push) begin
                if (!valid_q || pop) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data  = data_q;
    assign rx.rx_valid = valid_q;
`endif

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 1 clock/bit, one at 4 clocks/bit.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst4 = 1'b1;
    logic pin1 = 1'b1;
    logic pin4 = 1'b1;
    logic fe1, ov1, busy1;
    logic fe4, ov4, busy4;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0] q1[$];
    logic [7:0] q4[$];
    int unsigned fe1_n = 0, ov1_n = 0, fe4_n = 0, ov4_n = 0, busy4_n = 0;

    uart_rx_if if1 ();
    uart_rx_if if4 ();

    uart_rx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset(rst1), .rx_pin(pin1), .rx(if1),
        .frame_err(fe1), .overrun(ov1), .busy(busy1)
    );

    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .reset(rst4), .rx_pin(pin4), .rx(if4),
        .frame_err(fe4), .overrun(ov4), .busy(busy4)
    );

    always #5 clk = ~clk;

    // Record accepted bytes and flag/busy activity away from the active edge.
    always @(negedge clk) begin
        if (if1.rx_valid && if1.rx_ready) q1.push_back(if1.rx_data);
        if (if4.rx_valid && if4.rx_ready) q4.push_back(if4.rx_data);
        if (fe1) fe1_n++;
        if (ov1) ov1_n++;
        if (fe4) fe4_n++;
        if (ov4) ov4_n++;
        if (busy4) busy4_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive1(input logic v, input int n);
        pin1 = v;
        cycles(n);
    endtask

    task automatic drive4(input logic v, input int n);
        pin4 = v;
        cycles(n);
    endtask

    task automatic send1(input logic [7:0] b);
        drive1(1'b0, 1);
        for (int i = 0; i < 8; i++) drive1(b[i], 1);
        drive1(1'b1, 1);
    endtask

    task automatic send4(input logic [7:0] b, input logic stop);
        drive4(1'b0, 4);
        for (int i = 0; i < 8; i++) drive4(b[i], 4);
        drive4(stop, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string msg;
        int unsigned base, fbase, obase, bbase;
        logic [7:0] exp_pop[$];

        msg = "Tiny Tapeout ";
        if1.rx_ready = 1'b1;
        if4.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        cycles(3);
        rst1 = 1'b0;
        rst4 = 1'b0;

        check("rst_valid1", {31'd0, if1.rx_valid}, 32'd0);
        check("rst_data1",  {24'd0, if1.rx_data},  32'd0);
        check("rst_busy1",  {31'd0, busy1},        32'd0);
        check("rst_valid4", {31'd0, if4.rx_valid}, 32'd0);
        check("rst_data4",  {24'd0, if4.rx_data},  32'd0);
        check("rst_busy4",  {31'd0, busy4},        32'd0);
        check("rst_fe4",    {31'd0, fe4},          32'd0);
        check("rst_ov4",    {31'd0, ov4},          32'd0);

        // Single byte 0x54 at one clock per bit.
        drive1(1'b1, 4);
        send1(8'h54);
        drive1(1'b1, 6);
        check("t1_count", q1.size(), 32'd1);
        if (q1.size() > 0) check("t1_data", {24'd0, q1[0]}, 32'h54);
        check("t1_fe", fe1_n, 32'd0);
        check("t1_ov", ov1_n, 32'd0);
        check("t1_valid_low", {31'd0, if1.rx_valid}, 32'd0);

        // Back-to-back frames with no idle bits.
        base = q1.size();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < msg.len(); i++) send1(msg[i]);
        drive1(1'b1, 6);
        check("b2b_count", q1.size() - base, 2 * msg.len());
        for (int k = 0; k < 2 * msg.len(); k++)
            if (base + k < q1.size())
                check($sformatf("b2b_byte%0d", k), {24'd0, q1[base + k]}, {24'd0, msg[k % msg.len()]});
        check("b2b_fe", fe1_n, 32'd0);
        check("b2b_ov", ov1_n, 32'd0);

        // One-cycle glitch at four clocks per bit.
        drive4(1'b1, 4);
        base  = q4.size();
        bbase = busy4_n;
        drive4(1'b0, 1);
        drive4(1'b1, 10);
        check("gl_busy_seen", {31'd0, busy4_n > bbase}, 32'd1);
        check("gl_busy_end",  {31'd0, busy4}, 32'd0);
        check("gl_novalid",   q4.size() - base, 32'd0);
        check("gl_fe",        fe4_n, 32'd0);

        // Bad stop bit followed by a break, then a good frame.
        send4(8'hA5, 1'b0);
        drive4(1'b0, 20);
        check("fs_fe_once", fe4_n, 32'd1);
        check("fs_novalid", q4.size() - base, 32'd0);
        check("fs_busy_break", {31'd0, busy4}, 32'd1);
        drive4(1'b1, 6);
        check("fs_busy_idle", {31'd0, busy4}, 32'd0);
        send4(8'h3C, 1'b1);
        drive4(1'b1, 8);
        check("fs_next_count", q4.size() - base, 32'd1);
        if (q4.size() > base) check("fs_next_data", {24'd0, q4[base]}, 32'h3C);
        check("fs_fe_total", fe4_n, 32'd1);

        // Overrun with the consumer stalled.
        if4.rx_ready = 1'b0;
        base  = q4.size();
        obase = ov4_n;
`ifdef UART_RX_FIFO_EN
        send4(8'h11, 1'b1);
        send4(8'h22, 1'b1);
        send4(8'h33, 1'b1);
        send4(8'h44, 1'b1);
        send4(8'h55, 1'b1);
        exp_pop = '{8'h11, 8'h22, 8'h33, 8'h44};
`else
        send4(8'h11, 1'b1);
        send4(8'h22, 1'b1);
        exp_pop = '{8'h11};
`endif
        drive4(1'b1, 8);
        check("ov_pulse", ov4_n - obase, 32'd1);
        check("ov_head_valid", {31'd0, if4.rx_valid}, 32'd1);
        check("ov_head_data", {24'd0, if4.rx_data}, 32'h11);
        if4.rx_ready = 1'b1;
        cycles(8);
        check("ov_pop_count", q4.size() - base, exp_pop.size());
        for (int k = 0; k < exp_pop.size(); k++)
            if (base + k < q4.size())
                check($sformatf("ov_pop%0d", k), {24'd0, q4[base + k]}, {24'd0, exp_pop[k]});
        check("ov_drained", {31'd0, if4.rx_valid}, 32'd0);

        // Reset pulse during data bit 3.
        fbase = fe4_n;
        drive4(1'b0, 4);
        drive4(1'b0, 12);
        drive4(1'b0, 2);
        check("mr_busy_before", {31'd0, busy4}, 32'd1);
        rst4 = 1'b1;
        cycles(1);
        rst4 = 1'b0;
        pin4 = 1'b1;
        check("mr_valid", {31'd0, if4.rx_valid}, 32'd0);
        check("mr_data",  {24'd0, if4.rx_data},  32'd0);
        check("mr_busy",  {31'd0, busy4},        32'd0);
        check("mr_fe",    {31'd0, fe4},          32'd0);
        check("mr_ov",    {31'd0, ov4},          32'd0);
        base = q4.size();
        drive4(1'b1, 12);
        send4(8'h7E, 1'b1);
        drive4(1'b1, 8);
        check("mr_next_count", q4.size() - base, 32'd1);
        if (q4.size() > base) check("mr_next_data", {24'd0, q4[base]}, 32'h7E);
        check("mr_no_fe", fe4_n - fbase, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
